// File: rtl/lc2k_pkg.sv
// Shared LC2K definitions: opcodes, instruction field positions, fetch FSM encoding.
package lc2k_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_NOR  = 3'b001;
    localparam logic [2:0] OP_LW   = 3'b010;
    localparam logic [2:0] OP_SW   = 3'b011;
    localparam logic [2:0] OP_BEQ  = 3'b100;
    localparam logic [2:0] OP_JALR = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;
    localparam logic [2:0] OP_NOOP = 3'b111;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned REG_W      = 3;
    localparam int unsigned OFFSET_W   = 16;
    localparam int unsigned OPCODE_LSB = 22;
    localparam int unsigned REG_A_LSB  = 19;
    localparam int unsigned REG_B_LSB  = 16;
    localparam int unsigned DEST_LSB   = 0;
    localparam int unsigned OFFSET_LSB = 0;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  reg_a;
        logic [2:0]  reg_b;
        logic [2:0]  dest;
        logic [15:0] offset;
    } instr_fields_t;

endpackage

// File: rtl/lc2k_instr_fields.sv
// Combinational splitter of a 32-bit LC2K instruction word into its fields.
module lc2k_instr_fields
    import lc2k_pkg::*;
(
    input  logic [INSTR_W-1:0] instr_i,
    output instr_fields_t      fields_o
);

    logic unused_bits;

    always_comb begin
        fields_o.opcode = instr_i[OPCODE_LSB +: REG_W];
        fields_o.reg_a  = instr_i[REG_A_LSB  +: REG_W];
        fields_o.reg_b  = instr_i[REG_B_LSB  +: REG_W];
        fields_o.dest   = instr_i[DEST_LSB   +: REG_W];
        fields_o.offset = instr_i[OFFSET_LSB +: OFFSET_W];
    end

    // Bits above the opcode are architecturally unused.
    assign unused_bits = ^instr_i[INSTR_W-1:OPCODE_LSB+REG_W];

endmodule

// File: rtl/lc2k_fetch_unit.sv
// LC2K fetch stage: PC, imem req/ack fetch, field split, valid/ready issue, redirects, halt.
module lc2k_fetch_unit
    import lc2k_pkg::*;
#(
    parameter int unsigned          PC_WIDTH        = 16,
    parameter logic [PC_WIDTH-1:0]  RESET_PC        = '0,
    parameter int unsigned          STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [PC_WIDTH-1:0]        imem_addr,
    input  logic                       imem_ack,
    input  logic [31:0]                imem_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2:0]                 out_opcode,
    output logic [2:0]                 out_reg_a,
    output logic [2:0]                 out_reg_b,
    output logic [2:0]                 out_dest,
    output logic [15:0]                out_offset,
    output logic [PC_WIDTH-1:0]        out_pc,
    output logic [PC_WIDTH-1:0]        out_pc_plus1,
    input  logic                       redirect_valid,
    input  logic [PC_WIDTH-1:0]        redirect_pc,
    output logic                       halted,
    output logic [STALL_CNT_WIDTH-1:0] stall_count
);

    fetch_state_e               state_q, state_d;
    logic [PC_WIDTH-1:0]        pc_q, pc_d, pc_inc;
    logic                       discard_q, discard_d;
    logic                       req_q, req_d;
    logic [PC_WIDTH-1:0]        addr_q, addr_d;
    logic                       valid_q, valid_d;
    instr_fields_t              ir_q, ir_d, fetched;
    logic [PC_WIDTH-1:0]        out_pc_q, out_pc_d;
    logic [PC_WIDTH-1:0]        out_pc1_q, out_pc1_d;
    logic                       halted_q, halted_d;
    logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;
    logic                       ack_taken, handshake, stalled;

    lc2k_instr_fields u_fields (
        .instr_i  (imem_rdata),
        .fields_o (fetched)
    );

    assign pc_inc    = pc_q + PC_WIDTH'(1);
    assign ack_taken = req_q & imem_ack;
    assign handshake = valid_q & out_ready;
    assign stalled   = (req_q & ~imem_ack) | (valid_q & ~out_ready);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        discard_d = discard_q;
        valid_d   = valid_q;
        ir_d      = ir_q;
        out_pc_d  = out_pc_q;
        out_pc1_d = out_pc1_q;
        halted_d  = halted_q;

        case (state_q)
            ST_FETCH: begin
                if (ack_taken) begin
                    if (redirect_valid) begin
                        pc_d      = redirect_pc;
                        discard_d = 1'b0;
                    end else if (discard_q) begin
                        discard_d = 1'b0;
                    end else begin
                        ir_d      = fetched;
                        out_pc_d  = pc_q;
                        out_pc1_d = pc_inc;
                        valid_d   = 1'b1;
                        state_d   = ST_ISSUE;
                    end
                end else if (redirect_valid) begin
                    // Only a request already on the bus has to be absorbed later.
                    pc_d      = redirect_pc;
                    discard_d = discard_q | req_q;
                end
            end
            ST_ISSUE: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                    state_d = ST_FETCH;
                end else if (handshake) begin
                    pc_d    = pc_inc;
                    valid_d = 1'b0;
                    if (ir_q.opcode == OP_HALT) begin
                        halted_d = 1'b1;
                        state_d  = ST_HALTED;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_HALTED: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        req_d = (state_d == ST_FETCH);
        // The bus address is frozen while a request waits for its ack.
        addr_d = (req_q & ~imem_ack) ? addr_q : pc_d;

        stall_d = stall_q;
        if (stalled && (stall_q != '1)) begin
            stall_d = stall_q + STALL_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            discard_q <= 1'b0;
            req_q     <= 1'b0;
            addr_q    <= RESET_PC;
            valid_q   <= 1'b0;
            ir_q      <= '0;
            out_pc_q  <= '0;
            out_pc1_q <= '0;
            halted_q  <= 1'b0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            valid_q   <= valid_d;
            ir_q      <= ir_d;
            out_pc_q  <= out_pc_d;
            out_pc1_q <= out_pc1_d;
            halted_q  <= halted_d;
            stall_q   <= stall_d;
        end
    end

    assign imem_req     = req_q;
    assign imem_addr    = addr_q;
    assign out_valid    = valid_q;
    assign out_opcode   = ir_q.opcode;
    assign out_reg_a    = ir_q.reg_a;
    assign out_reg_b    = ir_q.reg_b;
    assign out_dest     = ir_q.dest;
    assign out_offset   = ir_q.offset;
    assign out_pc       = out_pc_q;
    assign out_pc_plus1 = out_pc1_q;
    assign halted       = halted_q;
    assign stall_count  = stall_q;

endmodule
